// File: rtl/tdm_transmit.sv
`timescale 1ns/1ps
// TDM serializer: one frame of SLOTS zero-padded samples per ws pulse, 1-bit delay after ws, MSB first.
// Latency: sd_out/sd_oe_out move on the 3rd clk_in edge after sck_in falls; status pulses 3 clk after the sck rise.
// Backpressure: one-entry pending buffer; ready_out low while full, audio_valid_in then is dropped with overflow_out.
module tdm_transmit #(
    parameter int SLOTS        = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sck_in,
    input  logic                           ws_in,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in [SLOTS],
    input  logic                           audio_valid_in,
    output logic                           ready_out,
    output logic                           sd_out,
    output logic                           sd_oe_out,
    output logic                           frame_start_out,
    output logic                           underrun_out,
    output logic                           overflow_out
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    typedef logic [SLOTS-1:0][SAMPLE_WIDTH-1:0] frame_t;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      sck_sync;
    logic [1:0]      ws_sync;
    logic            sck_rise, sck_fall, frame_go;
    logic [BW-1:0]   bit_cnt, bit_nxt, adv_bit;
    logic [SW-1:0]   slot_cnt, slot_nxt, adv_slot;
    logic            last_pos;
    logic            sd_nxt, oe_nxt;
    frame_t          buf_q, frame_q;
    logic            buf_full;
    logic            accept;

    // Slot word is the sample left-justified with zero padding below it.
    function automatic logic tx_bit(input frame_t f, input logic [SW-1:0] s, input logic [BW-1:0] b);
        logic [SLOT_WIDTH-1:0] w;
        w = '0;
        w[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = f[s];
        return w[BW'(SLOT_WIDTH-1) - b];
    endfunction

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sck_sync <= '0;
            ws_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck_in};
            ws_sync  <= {ws_sync[0], ws_in};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign frame_go = sck_rise & ws_sync[1];

    assign last_pos = (slot_cnt == SW'(SLOTS-1)) && (bit_cnt == BW'(SLOT_WIDTH-1));

    always_comb begin
        adv_bit  = bit_cnt + 1'b1;
        adv_slot = slot_cnt;
        if (bit_cnt == BW'(SLOT_WIDTH-1)) begin
            adv_bit  = '0;
            adv_slot = slot_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        slot_nxt  = slot_cnt;
        sd_nxt    = sd_out;
        oe_nxt    = sd_oe_out;
        if (frame_go) begin
            // A frame sync always wins, even mid-frame; the line holds its bit until the next fall.
            state_nxt = ARMED;
            bit_nxt   = '0;
            slot_nxt  = '0;
        end else begin
            unique case (state)
                ARMED: begin
                    if (sck_fall) begin
                        state_nxt = SHIFT;
                        bit_nxt   = '0;
                        slot_nxt  = '0;
                        sd_nxt    = tx_bit(frame_q, '0, '0);
                        oe_nxt    = 1'b1;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        if (last_pos) begin
                            state_nxt = IDLE;
                            sd_nxt    = 1'b0;
                            oe_nxt    = 1'b0;
                        end else begin
                            bit_nxt  = adv_bit;
                            slot_nxt = adv_slot;
                            sd_nxt   = tx_bit(frame_q, adv_slot, adv_bit);
                            oe_nxt   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            slot_cnt  <= '0;
            sd_out    <= 1'b0;
            sd_oe_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            slot_cnt  <= slot_nxt;
            sd_out    <= sd_nxt;
            sd_oe_out <= oe_nxt;
        end
    end

    // A frame start frees the buffer on the same edge, so a coincident load is accepted, not dropped.
    assign accept    = audio_valid_in && (!buf_full || frame_go);
    assign ready_out = ~buf_full;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            buf_q           <= '0;
            buf_full        <= 1'b0;
            frame_q         <= '0;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
            overflow_out    <= 1'b0;
        end else begin
            frame_start_out <= frame_go;
            underrun_out    <= frame_go && !buf_full;
            overflow_out    <= audio_valid_in && buf_full && !frame_go;
            if (frame_go && buf_full) begin
                frame_q <= buf_q;
            end
            if (accept) begin
                for (int i = 0; i < SLOTS; i++) begin
                    buf_q[i] <= audio_in[i];
                end
                buf_full <= 1'b1;
            end else if (frame_go) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_transmit.sv
`timescale 1ns/1ps
// Bench for tdm_transmit: drives sck/ws at 50 clk periods per bit and checks frames against a buffer/frame model.
module tb_tdm_transmit;

    localparam int SLOTS = 2;
    localparam int SW    = 24;
    localparam int SLW   = 32;
    localparam int TOTAL = SLOTS * SLW;

    typedef logic [SW-1:0] set_t [SLOTS];

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b0;
    logic                 sck_in = 1'b0;
    logic                 ws_in = 1'b0;
    logic signed [SW-1:0] audio_in [SLOTS];
    logic                 audio_valid_in = 1'b0;
    logic                 ready_out, sd_out, sd_oe_out, frame_start_out, underrun_out, overflow_out;

    int n_cmp = 0;
    int n_fail = 0;
    int n_fs = 0;
    int n_ur = 0;
    int n_ov = 0;

    logic cap_sd [TOTAL];
    logic cap_oe [TOTAL];

    // Reference model: one pending set plus the set currently on the line.
    set_t m_pend;
    set_t m_frame;
    bit   m_full;

    tdm_transmit #(.SLOTS(SLOTS), .SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sck_in(sck_in), .ws_in(ws_in),
        .audio_in(audio_in), .audio_valid_in(audio_valid_in), .ready_out(ready_out),
        .sd_out(sd_out), .sd_oe_out(sd_oe_out), .frame_start_out(frame_start_out),
        .underrun_out(underrun_out), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_start_out === 1'b1) n_fs++;
        if (underrun_out === 1'b1) n_ur++;
        if (overflow_out === 1'b1) n_ov++;
    end

    function automatic set_t rnd_set();
        set_t s;
        for (int i = 0; i < SLOTS; i++) s[i] = SW'($urandom);
        return s;
    endfunction

    function automatic logic [SLW-1:0] exp_word(input logic [SW-1:0] smp);
        return {smp, {(SLW-SW){1'b0}}};
    endfunction

    function automatic logic [SLW-1:0] cap_word(input int s);
        logic [SLW-1:0] w;
        for (int b = 0; b < SLW; b++) w[SLW-1-b] = cap_sd[s*SLW+b];
        return w;
    endfunction

    function automatic logic cap_oe_all(input int s);
        logic a;
        a = 1'b1;
        for (int b = 0; b < SLW; b++) a = a & cap_oe[s*SLW+b];
        return a;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            m_pend[i]  = '0;
            m_frame[i] = '0;
        end
    endtask

    task automatic model_frame(output bit ur);
        ur = !m_full;
        if (m_full) begin
            m_frame = m_pend;
            m_full  = 1'b0;
        end
    endtask

    task automatic load_set(input set_t d, output bit ovf);
        ovf = m_full;
        if (!m_full) begin
            m_pend = d;
            m_full = 1'b1;
        end
        @(negedge clk_in);
        for (int i = 0; i < SLOTS; i++) audio_in[i] = $signed(d[i]);
        audio_valid_in = 1'b1;
        @(negedge clk_in);
        audio_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    // One sck period: fall, hold low, rise (receiver samples), hold high. Also checks output update timing.
    task automatic bit_period(input logic ws_v, output logic sd_c, output logic oe_c);
        logic sd0, oe0, sd2, oe2, sd3, oe3;
        sck_in = 1'b0;
        ws_in  = ws_v;
        sd0 = sd_out; oe0 = sd_oe_out;
        #20;
        sd2 = sd_out; oe2 = sd_oe_out;
        #10;
        sd3 = sd_out; oe3 = sd_oe_out;
        #220;
        sck_in = 1'b1;
        sd_c = sd_out;
        oe_c = sd_oe_out;
        n_cmp++;
        if ({sd2, oe2} !== {sd0, oe0} || {sd3, oe3} !== {sd_c, oe_c}) begin
            n_fail++;
            $display("FAIL edge_timing t=%0t: sd/oe before=%b%b after2=%b%b after3=%b%b at_rise=%b%b",
                     $time, sd0, oe0, sd2, oe2, sd3, oe3, sd_c, oe_c);
        end
        #250;
    endtask

    task automatic start_frame();
        logic s, o;
        bit_period(1'b1, s, o);
    endtask

    task automatic capture(input int n);
        logic s, o;
        for (int k = 0; k < n; k++) begin
            bit_period(1'b0, s, o);
            cap_sd[k] = s;
            cap_oe[k] = o;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        for (int i = 0; i < SLOTS; i++) audio_in[i] = '0;
        #100;
        n_cmp++; if (sd_out !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b expected 0", sd_out); end
        n_cmp++; if (sd_oe_out !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", sd_oe_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
        n_cmp++; if ({frame_start_out, underrun_out, overflow_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 000", {frame_start_out, underrun_out, overflow_out});
        end
        rst_in = 1'b1;
        model_reset();
        #100;
    endtask

    task automatic test_basic();
        set_t d;
        bit eo, eu;
        int fs0, ur0;
        logic s, o;
        d[0] = 24'h123456;
        d[1] = 24'hABCDEF;
        load_set(d, eo);
        n_cmp++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after_load: got %b expected 0", ready_out); end
        fs0 = n_fs; ur0 = n_ur;
        model_frame(eu);
        start_frame();
        n_cmp++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL basic_ready_at_start: got %b expected 1", ready_out); end
        n_cmp++; if (n_fs - fs0 !== 1) begin n_fail++; $display("FAIL basic_frame_start: got %0d pulses expected 1", n_fs - fs0); end
        n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL basic_underrun: got %0d expected %0d", n_ur - ur0, eu); end
        capture(TOTAL);
        n_cmp++; if (cap_word(0) !== 32'h12345600) begin n_fail++; $display("FAIL basic_slot0: got %h expected 12345600", cap_word(0)); end
        n_cmp++; if (cap_word(1) !== 32'hABCDEF00) begin n_fail++; $display("FAIL basic_slot1: got %h expected abcdef00", cap_word(1)); end
        for (int sl = 0; sl < SLOTS; sl++) begin
            n_cmp++; if (cap_oe_all(sl) !== 1'b1) begin n_fail++; $display("FAIL basic_oe slot %0d: got 0 expected 1", sl); end
        end
        bit_period(1'b0, s, o);
        n_cmp++; if ({s, o} !== 2'b00) begin n_fail++; $display("FAIL basic_trailing: got sd/oe %b%b expected 00", s, o); end
    endtask

    task automatic test_underrun();
        bit eo, eu;
        int ur0;
        logic s, o;
        load_set(rnd_set(), eo);
        for (int f = 0; f < 2; f++) begin
            ur0 = n_ur;
            model_frame(eu);
            start_frame();
            n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL underrun_frame%0d: got %0d expected %0d", f, n_ur - ur0, eu); end
            capture(TOTAL);
            for (int sl = 0; sl < SLOTS; sl++) begin
                n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                    n_fail++; $display("FAIL underrun_data f%0d s%0d: got %h expected %h", f, sl, cap_word(sl), exp_word(m_frame[sl]));
                end
            end
            bit_period(1'b0, s, o);
        end
    endtask

    task automatic test_overflow();
        bit eo1, eo2, eu;
        int ov0;
        logic s, o;
        ov0 = n_ov;
        load_set(rnd_set(), eo1);
        load_set(rnd_set(), eo2);
        n_cmp++; if (n_ov - ov0 !== int'(eo1) + int'(eo2)) begin
            n_fail++; $display("FAIL overflow_count: got %0d expected %0d", n_ov - ov0, int'(eo1) + int'(eo2));
        end
        n_cmp++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL overflow_ready: got %b expected 0", ready_out); end
        model_frame(eu);
        start_frame();
        capture(TOTAL);
        for (int sl = 0; sl < SLOTS; sl++) begin
            n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                n_fail++; $display("FAIL overflow_data s%0d: got %h expected %h", sl, cap_word(sl), exp_word(m_frame[sl]));
            end
        end
        bit_period(1'b0, s, o);
    endtask

    task automatic test_abort();
        bit eo, eu;
        int fs0, ur0;
        logic s, o;
        load_set(rnd_set(), eo);
        model_frame(eu);
        start_frame();
        capture(20);
        n_cmp++; if ((cap_word(0) >> 12) !== (exp_word(m_frame[0]) >> 12)) begin
            n_fail++; $display("FAIL abort_partial: got %h expected %h", cap_word(0) >> 12, exp_word(m_frame[0]) >> 12);
        end
        load_set(rnd_set(), eo);
        fs0 = n_fs; ur0 = n_ur;
        model_frame(eu);
        start_frame();
        n_cmp++; if (n_fs - fs0 !== 1) begin n_fail++; $display("FAIL abort_frame_start: got %0d expected 1", n_fs - fs0); end
        n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL abort_underrun: got %0d expected %0d", n_ur - ur0, eu); end
        capture(TOTAL);
        for (int sl = 0; sl < SLOTS; sl++) begin
            n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                n_fail++; $display("FAIL abort_data s%0d: got %h expected %h", sl, cap_word(sl), exp_word(m_frame[sl]));
            end
        end
        bit_period(1'b0, s, o);
        n_cmp++; if ({s, o} !== 2'b00) begin n_fail++; $display("FAIL abort_trailing: got %b%b expected 00", s, o); end
    endtask

    // Frame start and a new load land on the same clk edge while the buffer is full.
    task automatic test_back_to_back();
        bit eo, eu;
        set_t nb;
        int ov0, ur0, fs0;
        logic s, o;
        load_set(rnd_set(), eo);
        nb = rnd_set();
        ov0 = n_ov; ur0 = n_ur; fs0 = n_fs;
        model_frame(eu);
        m_pend = nb;
        m_full = 1'b1;
        sck_in = 1'b0; ws_in = 1'b1;
        #250;
        sck_in = 1'b1;
        #20;
        for (int i = 0; i < SLOTS; i++) audio_in[i] = $signed(nb[i]);
        audio_valid_in = 1'b1;
        #10;
        audio_valid_in = 1'b0;
        #220;
        n_cmp++; if (n_ov - ov0 !== 0) begin n_fail++; $display("FAIL b2b_overflow: got %0d expected 0", n_ov - ov0); end
        n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL b2b_underrun: got %0d expected %0d", n_ur - ur0, eu); end
        n_cmp++; if (n_fs - fs0 !== 1) begin n_fail++; $display("FAIL b2b_frame_start: got %0d expected 1", n_fs - fs0); end
        n_cmp++; if (ready_out !== !m_full) begin n_fail++; $display("FAIL b2b_ready: got %b expected %b", ready_out, !m_full); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                ur0 = n_ur;
                model_frame(eu);
                start_frame();
                n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL b2b_underrun2: got %0d expected %0d", n_ur - ur0, eu); end
            end
            capture(TOTAL);
            for (int sl = 0; sl < SLOTS; sl++) begin
                n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                    n_fail++; $display("FAIL b2b_data f%0d s%0d: got %h expected %h", f, sl, cap_word(sl), exp_word(m_frame[sl]));
                end
            end
            bit_period(1'b0, s, o);
        end
    endtask

    task automatic test_reset_mid();
        bit eo, eu;
        int ur0;
        logic s, o;
        load_set(rnd_set(), eo);
        model_frame(eu);
        start_frame();
        capture(40);
        load_set(rnd_set(), eo);
        sck_in = 1'b0;
        #100;
        rst_in = 1'b0;
        #1;
        n_cmp++; if (sd_oe_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b expected 0", sd_oe_out); end
        n_cmp++; if (sd_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_sd: got %b expected 0", sd_out); end
        n_cmp++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", ready_out); end
        #99;
        rst_in = 1'b1;
        model_reset();
        #50;
        sck_in = 1'b1;
        #250;
        for (int k = 0; k < 4; k++) begin
            bit_period(1'b0, s, o);
            n_cmp++; if (o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_oe bit %0d: got %b expected 0", k, o); end
        end
        ur0 = n_ur;
        model_frame(eu);
        start_frame();
        n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL rstmid_underrun: got %0d expected %0d", n_ur - ur0, eu); end
        capture(TOTAL);
        for (int sl = 0; sl < SLOTS; sl++) begin
            n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                n_fail++; $display("FAIL rstmid_data s%0d: got %h expected %h", sl, cap_word(sl), exp_word(m_frame[sl]));
            end
            n_cmp++; if (cap_oe_all(sl) !== 1'b1) begin n_fail++; $display("FAIL rstmid_oe_slot %0d: got 0 expected 1", sl); end
        end
        bit_period(1'b0, s, o);
    endtask

    task automatic test_random();
        bit eo, eu;
        int nl, ov0, ur0, ov_exp;
        logic s, o;
        for (int it = 0; it < 4; it++) begin
            nl = $urandom_range(0, 2);
            ov0 = n_ov;
            ov_exp = 0;
            for (int j = 0; j < nl; j++) begin
                load_set(rnd_set(), eo);
                ov_exp += int'(eo);
            end
            n_cmp++; if (n_ov - ov0 !== ov_exp) begin n_fail++; $display("FAIL rand_overflow it%0d: got %0d expected %0d", it, n_ov - ov0, ov_exp); end
            ur0 = n_ur;
            model_frame(eu);
            start_frame();
            n_cmp++; if (n_ur - ur0 !== int'(eu)) begin n_fail++; $display("FAIL rand_underrun it%0d: got %0d expected %0d", it, n_ur - ur0, eu); end
            capture(TOTAL);
            for (int sl = 0; sl < SLOTS; sl++) begin
                n_cmp++; if (cap_word(sl) !== exp_word(m_frame[sl])) begin
                    n_fail++; $display("FAIL rand_data it%0d s%0d: got %h expected %h", it, sl, cap_word(sl), exp_word(m_frame[sl]));
                end
            end
            bit_period(1'b0, s, o);
            n_cmp++; if ({s, o} !== 2'b00) begin n_fail++; $display("FAIL rand_trailing it%0d: got %b%b expected 00", it, s, o); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_transmit.md
TDM_TRANSMIT -- requirements
Module: tdm_transmit

Interface
REQ-001 SHALL have parameter SLOTS, default 2: number of TDM slots per frame.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24: signed sample bits per slot.
REQ-003 SHALL have parameter SLOT_WIDTH, default 32: sck_in periods per slot; SLOT_WIDTH >= SAMPLE_WIDTH.
REQ-004 SHALL have port clk_in, input, 1 bit: single system clock (100 MHz); all logic is in this domain.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sck_in, input, 1 bit: TDM bit clock from the receiver, asynchronous to clk_in.
REQ-007 SHALL have port ws_in, input, 1 bit: TDM frame-sync pulse, asynchronous to clk_in.
REQ-008 SHALL have port audio_in, input, SLOTS x SAMPLE_WIDTH signed array: samples for the next frame; index 0 is slot 0.
REQ-009 SHALL have port audio_valid_in, input, 1 bit: audio_in is valid this cycle.
REQ-010 SHALL have port ready_out, output, 1 bit: pending buffer is empty and can accept a sample set.
REQ-011 SHALL have port sd_out, output, 1 bit: serial data to the TDM line.
REQ-012 SHALL have port sd_oe_out, output, 1 bit: high while this block drives sd_out inside a valid slot.
REQ-013 SHALL have port frame_start_out, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-014 SHALL have port underrun_out, output, 1 bit: one-cycle pulse when a frame starts with no new sample set.
REQ-015 SHALL have port overflow_out, output, 1 bit: one-cycle pulse when audio_valid_in arrives while ready_out is low.

Function
REQ-016 SHALL pass sck_in and ws_in through a 2-flop synchronizer and detect sck rising and falling edges against a third registered copy.
REQ-017 SHALL use a 1-entry pending buffer: audio_valid_in && ready_out loads the buffer and drops ready_out on the next cycle.
REQ-018 SHALL ignore audio_valid_in while ready_out is low, leave the buffer unchanged, and pulse overflow_out.
REQ-019 SHALL run the state machine IDLE -> ARMED -> SHIFT -> IDLE.
REQ-020 SHALL treat a detected sck rising edge with synchronized ws high as a frame start in any state: go to ARMED, clear the bit counter, and pulse frame_start_out.
REQ-021 SHALL, at frame start, copy the pending buffer into the frame shift register and raise ready_out if the buffer is full; otherwise reuse the previous frame's samples (zero after reset) and pulse underrun_out.
REQ-022 SHALL, on the first sck falling edge in ARMED, drive slot 0 MSB and go to SHIFT; this gives a 1-bit delay after ws, as the receiver expects.
REQ-023 SHALL, in SHIFT, advance one bit per sck falling edge; bit counter runs 0 .. SLOTS*SLOT_WIDTH-1.
REQ-024 SHALL format each slot as SAMPLE_WIDTH bits MSB-first, then SLOT_WIDTH-SAMPLE_WIDTH zero bits, with sd_oe_out high for the whole slot.
REQ-025 SHALL, after the last bit's period (next falling edge once the counter reaches SLOTS*SLOT_WIDTH-1), drive sd_out 0 and sd_oe_out 0 and return to IDLE.
REQ-026 SHALL register sd_out and sd_oe_out and update them on the 3rd clk_in rising edge after sck_in falls at the pin.
REQ-027 SHALL abandon a frame in progress when ws arrives mid-frame and restart per REQ-020, with no underrun/overflow side effects beyond REQ-021.
REQ-028 SHALL pulse underrun_out and overflow_out both in the same cycle if both conditions occur in that cycle.
REQ-029 SHALL, when frame start and audio_valid_in with a full buffer coincide, transfer the old buffer first, then accept the new data into the freed buffer on the same edge, with no overflow_out pulse.

Reset
REQ-030 SHALL, while rst_in is low, immediately set the state to IDLE and force sd_out=0, sd_oe_out=0, ready_out=1, frame_start_out=0, underrun_out=0, overflow_out=0.
REQ-031 SHALL, while rst_in is low, also clear the pending buffer, the frame register, the bit counter and the synchronizers.
REQ-032 SHALL, if reset is asserted mid-frame, stop driving within reset, and after release SHALL transmit nothing until the next ws frame start.

Verification
REQ-033 SHALL cover: SLOTS=2, sck = 50 clk_in periods, load {24'h123456, 24'hABCDEF}, one ws pulse -> receiver model captures slot0 32'h12345600 and slot1 32'hABCDEF00; ready_out returns to 1 at frame start.
REQ-034 SHALL cover: two consecutive frames with no load before the 2nd -> underrun_out pulses once, and frame 2 repeats frame 1's data.
REQ-035 SHALL cover: two audio_valid_in pulses with no frame between them -> 2nd is dropped, overflow_out pulses once, and the next frame carries the 1st set.
REQ-036 SHALL cover: ws re-asserted at bit 20 of slot 0 -> new frame starts with slot 0 MSB on the next falling edge and frame_start_out pulses.
REQ-037 SHALL cover: rst_in pulsed low at bit 40 -> sd_oe_out=0 immediately, ready_out=1, and the next frame after release sends zeros with underrun_out=1.
REQ-038 SHALL cover: sd_out changes exactly 3 clk_in edges after each sck_in falling edge, and the value is stable at every sck_in rising edge.
